// File: rtl/dm_arb_pkg.sv
// Shared definitions for the DataMemory port arbiter.
//   arb_state_e : arbiter FSM states
//   OWN_*       : request owner encoding held in the request registers
//   *_W_DEF     : default data/address widths of DataMemory
package dm_arb_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_IO   = 1'b1;

endpackage

// File: rtl/dm_arb_priority.sv
// Bounded-priority winner select for the DataMemory arbiter.
//   clk, rst_n   : clock, async active-low reset
//   arb_en       : arbiter is in a cycle where a new grant may be issued
//   core_elig    : core request is eligible this cycle
//   io_elig      : I/O request is eligible this cycle
//   io_req       : raw I/O request level (drives the starvation counter clear)
//   grant_valid  : a grant is issued this cycle
//   grant_io     : winner is the I/O port (meaningful when grant_valid)
// The core wins by default; once it has won STARVE_MAX times in a row while
// the I/O port was waiting, the I/O port is forced to win.
module dm_arb_priority #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arb_en,
  input  logic core_elig,
  input  logic io_elig,
  input  logic io_req,
  output logic grant_valid,
  output logic grant_io
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

  logic [CntW-1:0] starve_q, starve_d;
  logic            starve_hit;

  assign starve_hit = (starve_q == CntMax);

  always_comb begin
    grant_valid = arb_en & (core_elig | io_elig);
    grant_io    = io_elig & (~core_elig | starve_hit);
  end

  always_comb begin
    starve_d = starve_q;
    if (!io_req) begin
      starve_d = '0;
    end else if (grant_valid && grant_io) begin
      starve_d = '0;
    end else if (grant_valid && !starve_hit) begin
      // core grant while I/O is waiting; saturates at CntMax
      starve_d = starve_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Two-port arbiter sharing the single-port DataMemory between the CORE
// load/store path (port 0) and the calculator I/O agent (port 1).
//   CLK, RST          : clock, async active-low reset
//   CORE_* / IO_*     : req/ack request ports; REQ held until ACK, fields
//                       stable while REQ is high; RDATA valid with ACK
//   CORE_STALL        : CORE_REQ & ~CORE_ACK, freezes the core PC/IR
//   MEM_ADDR/IN/WE    : to DataMemory ADDR/IN/EN
//   MEM_OUT           : DataMemory combinational read data
//   BUSY              : arbiter is not idle
// Each access is IDLE/RESP (grant) -> ACCESS (1 cycle) -> RESP (ack, 1 cycle).
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CORE_REQ,
  input  logic              CORE_WE,
  input  logic [ADDR_W-1:0] CORE_ADDR,
  input  logic [DATA_W-1:0] CORE_WDATA,
  output logic              CORE_ACK,
  output logic [DATA_W-1:0] CORE_RDATA,
  output logic              CORE_STALL,
  input  logic              IO_REQ,
  input  logic              IO_WE,
  input  logic [ADDR_W-1:0] IO_ADDR,
  input  logic [DATA_W-1:0] IO_WDATA,
  output logic              IO_ACK,
  output logic [DATA_W-1:0] IO_RDATA,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_IN,
  output logic              MEM_WE,
  input  logic [DATA_W-1:0] MEM_OUT,
  output logic              BUSY
);

  arb_state_e        state_q, state_d;
  logic              owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] core_rdata_q;
  logic [DATA_W-1:0] io_rdata_q;

  logic arb_en;
  logic in_resp;
  logic core_elig;
  logic io_elig;
  logic grant_valid;
  logic grant_io;
  logic grant;

  assign arb_en  = (state_q == IDLE) || (state_q == RESP);
  assign in_resp = (state_q == RESP);

  // The port being acked still holds REQ for its own completed access.
  assign core_elig = CORE_REQ & ~(in_resp & (owner_q == OWN_CORE));
  assign io_elig   = IO_REQ & ~(in_resp & (owner_q == OWN_IO));

  dm_arb_priority #(
    .STARVE_MAX(STARVE_MAX)
  ) u_prio (
    .clk        (CLK),
    .rst_n      (RST),
    .arb_en     (arb_en),
    .core_elig  (core_elig),
    .io_elig    (io_elig),
    .io_req     (IO_REQ),
    .grant_valid(grant_valid),
    .grant_io   (grant_io)
  );

  assign grant = grant_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = grant ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      owner_q      <= OWN_CORE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      core_rdata_q <= '0;
      io_rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      // Captured for writes too: the old memory word, harmless and deterministic.
      if (state_q == ACCESS) begin
        if (owner_q == OWN_IO) begin
          io_rdata_q <= MEM_OUT;
        end else begin
          core_rdata_q <= MEM_OUT;
        end
      end
      if (grant) begin
        owner_q <= grant_io;
        we_q    <= grant_io ? IO_WE : CORE_WE;
        addr_q  <= grant_io ? IO_ADDR : CORE_ADDR;
        wdata_q <= grant_io ? IO_WDATA : CORE_WDATA;
      end
    end
  end

  // State resets asynchronously, so an in-flight write is cut off at once.
  assign MEM_WE     = we_q & (state_q == ACCESS);
  assign MEM_ADDR   = addr_q;
  assign MEM_IN     = wdata_q;

  assign CORE_ACK   = in_resp & (owner_q == OWN_CORE);
  assign IO_ACK     = in_resp & (owner_q == OWN_IO);
  assign CORE_RDATA = core_rdata_q;
  assign IO_RDATA   = io_rdata_q;
  assign CORE_STALL = CORE_REQ & ~CORE_ACK;
  assign BUSY       = (state_q != IDLE);

endmodule
